// File: rtl/dmem_responder_pkg.sv
// ---------------------------------------------------------------------------
// dmem_responder_pkg
// Shared definitions for the data-memory responder:
//   - access-size encodings carried on req_wbh
//   - FSM state enumeration
//   - default byte-address width
//   - helpers for request validation and read-lane extraction
// ---------------------------------------------------------------------------
package dmem_responder_pkg;

    localparam int ADDR_W_DEF = 13;

    localparam logic [1:0] WBH_WORD = 2'b00;
    localparam logic [1:0] WBH_HALF = 2'b01;
    localparam logic [1:0] WBH_BYTE = 2'b10;
    localparam logic [1:0] WBH_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_t;

    // A request is rejected for the reserved size or a misaligned address.
    function automatic logic req_is_err(input logic [1:0] wbh, input logic [1:0] lo);
        logic err;
        err = 1'b0;
        case (wbh)
            WBH_WORD: err = (lo != 2'b00);
            WBH_HALF: err = lo[0];
            WBH_BYTE: err = 1'b0;
            default:  err = 1'b1;
        endcase
        return err;
    endfunction

    // Select the addressed lane of a little-endian word, zero-extended.
    function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                                 input logic [1:0]  wbh,
                                                 input logic [1:0]  lo);
        logic [31:0] res;
        res = word;
        case (wbh)
            WBH_BYTE: begin
                case (lo)
                    2'd0:    res = {24'd0, word[7:0]};
                    2'd1:    res = {24'd0, word[15:8]};
                    2'd2:    res = {24'd0, word[23:16]};
                    default: res = {24'd0, word[31:24]};
                endcase
            end
            WBH_HALF: res = lo[1] ? {16'd0, word[31:16]} : {16'd0, word[15:0]};
            default:  res = word;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// ---------------------------------------------------------------------------
// dmem_array
// Single-port word RAM with synchronous (registered) read and a full-word
// write enable. Contents are never cleared; there is no reset.
// Ports:
//   i_clk    clock
//   i_we     write i_wdata to word i_addr on the rising edge
//   i_re     register word i_addr onto o_rdata on the rising edge
//   i_addr   word index
//   i_wdata  write word
//   o_rdata  registered read word (holds its value when i_re=0)
// ---------------------------------------------------------------------------
module dmem_array #(
    parameter int AW = 11
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic          i_re,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [0:(1<<AW)-1];
    logic [31:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
// Valid/ready data-memory slave. Accepts one request at a time, performs a
// read, word write or read-modify-write sub-word write on a word RAM, and
// presents a single response that is held until consumed.
// Ports:
//   clock, reset        clock; synchronous active-low reset
//   req_valid/req_ready request handshake (ready only in IDLE)
//   req_wena            1 = write, 0 = read
//   req_wbh             size: 00 word, 01 halfword, 10 byte, 11 reserved
//   req_addr            byte address
//   req_wdata           right-aligned write data
//   resp_valid/ready    response handshake (valid only in RESP)
//   resp_rdata          zero-extended read lane; 0 for writes/errors
//   resp_err            misaligned or reserved-size request
// ---------------------------------------------------------------------------
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wena,
    input  logic [1:0]        req_wbh,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err
);

    localparam int IDX_W = ADDR_W - 2;

    state_t            r_state;
    state_t            w_state_next;
    logic              r_live;      // low while reset is held, keeps req_ready at 0
    logic              r_wena;
    logic [1:0]        r_wbh;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_err;

    logic              w_accept;
    logic              w_ram_we;
    logic              w_ram_re;
    logic [31:0]       w_ram_rdata;
    logic [31:0]       w_ram_wdata;
    logic [31:0]       w_merged;

    assign req_ready = (r_state == IDLE) && r_live;
    assign w_accept  = req_valid && req_ready;

    // ---------------- state and request capture ----------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= IDLE;
            r_live  <= 1'b0;
            r_wena  <= 1'b0;
            r_wbh   <= WBH_WORD;
            r_addr  <= '0;
            r_wdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_live  <= 1'b1;
            if (w_accept) begin
                r_wena  <= req_wena;
                r_wbh   <= req_wbh;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_err   <= req_is_err(req_wbh, req_addr[1:0]);
            end
        end
    end

    // ---------------- next state ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (req_is_err(req_wbh, req_addr[1:0])) begin
                        w_state_next = RESP;
                    end else if (req_wena && (req_wbh == WBH_WORD)) begin
                        w_state_next = WR;
                    end else begin
                        w_state_next = RD;
                    end
                end
            end
            RD:      w_state_next = r_wena ? WR : RESP;
            WR:      w_state_next = RESP;
            RESP:    w_state_next = resp_ready ? IDLE : RESP;
            default: w_state_next = IDLE;
        endcase
    end

    // ---------------- sub-word merge ----------------
    // Each byte lane takes the write data when it is addressed, otherwise the
    // word fetched in RD. A word write selects all lanes.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            logic       w_sel;
            logic [7:0] w_byte;
            always_comb begin
                w_sel  = 1'b1;
                w_byte = r_wdata[8*gi +: 8];
                case (r_wbh)
                    WBH_BYTE: begin
                        w_sel  = (r_addr[1:0] == LANE);
                        w_byte = r_wdata[7:0];
                    end
                    WBH_HALF: begin
                        w_sel  = (r_addr[1] == LANE[1]);
                        w_byte = r_wdata[8*(gi%2) +: 8];
                    end
                    default: begin
                        w_sel  = 1'b1;
                        w_byte = r_wdata[8*gi +: 8];
                    end
                endcase
            end
            assign w_merged[8*gi +: 8] = w_sel ? w_byte : w_ram_rdata[8*gi +: 8];
        end
    endgenerate

    assign w_ram_wdata = (r_wbh == WBH_WORD) ? r_wdata : w_merged;

    // Reset arriving while in WR must cancel the pending write.
    assign w_ram_we = (r_state == WR) && reset;
    assign w_ram_re = (r_state == RD);

    dmem_array #(
        .AW(IDX_W)
    ) u_array (
        .i_clk   (clock),
        .i_we    (w_ram_we),
        .i_re    (w_ram_re),
        .i_addr  (r_addr[ADDR_W-1:2]),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_rdata)
    );

    // ---------------- response ----------------
    // The RAM output register only changes in RD, so the read lane is stable
    // for the whole RESP state.
    assign resp_valid = (r_state == RESP);
    assign resp_err   = (r_state == RESP) && r_err;
    assign resp_rdata = ((r_state == RESP) && !r_err && !r_wena)
                        ? lane_extract(w_ram_rdata, r_wbh, r_addr[1:0])
                        : 32'd0;

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter ADDR_W, default 13: byte-address width; storage holds 2**(ADDR_W-2) 32-bit words (2048 at default).
REQ-002 clock  input  1  sole clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-low reset (0 = reset asserted), sampled on the rising edge of clock.
REQ-004 req_valid  input  1  the CPU side presents a request.
REQ-005 req_ready  output  1  the responder accepts a request this cycle.
REQ-006 req_wena  input  1  1 = write, 0 = read.
REQ-007 req_wbh  input  2  access size: 00 word, 01 halfword, 10 byte, 11 reserved.
REQ-008 req_addr  input  ADDR_W  byte address.
REQ-009 req_wdata  input  32  write data, right-aligned (the halfword is in [15:0], the byte is in [7:0]).
REQ-010 resp_valid  output  1  a response is pending.
REQ-011 resp_ready  input  1  the CPU side consumes the response.
REQ-012 resp_rdata  output  32  read data; the selected lane is zero-extended; 0 for writes and errors.
REQ-013 resp_err  output  1  the request was rejected (misaligned or reserved size).

Function
REQ-014 A request SHALL be accepted only on a cycle where req_valid=1 and req_ready=1; all request fields SHALL be captured at that edge.
REQ-015 req_ready SHALL be 1 only in state IDLE.
REQ-016 The FSM SHALL have the states IDLE, RD, WR and RESP:
  - IDLE -> RD on accept of a read or a sub-word write.
  - IDLE -> WR on accept of a word write.
  - IDLE -> RESP on accept of an erroneous request.
  - RD -> WR for a sub-word write; RD -> RESP for a read.
  - WR -> RESP.
  - RESP -> IDLE when resp_ready=1.
REQ-017 Latency from accept to first resp_valid SHALL be:
  - read: 2 cycles.
  - word write: 2 cycles.
  - sub-word write: 3 cycles (read-modify-write).
  - error: 1 cycle.
REQ-018 The memory array SHALL be read synchronously in RD, with the word index equal to addr[ADDR_W-1:2].
REQ-019 Byte lanes SHALL be little-endian: byte k occupies bits [8k+7:8k]; halfword h occupies bits [16h+15:16h].
REQ-020 A sub-word write SHALL merge only the addressed lane into the word read in RD and write the merged word in WR; all other lanes SHALL be unchanged.
REQ-021 resp_err SHALL be 1 when any of these holds, and in that case no memory write SHALL occur:
  - req_wbh=11.
  - a word access with addr[1:0]!=0.
  - a halfword access with addr[0]!=0.
REQ-022 resp_valid, resp_rdata and resp_err SHALL be held stable while in RESP until resp_ready=1.
REQ-023 resp_valid SHALL be 1 only in RESP; a new request SHALL NOT be accepted in the cycle resp_ready=1 is sampled, so back-to-back requests are accepted at the earliest on the following cycle.
REQ-024 A read issued after a write to the same address SHALL return the written data (the write completes in WR before RESP).
REQ-025 req_valid in a non-IDLE state SHALL be ignored and has no side effect.

Reset
REQ-026 While reset=0 the FSM SHALL go to IDLE and the outputs SHALL be: req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0; req_ready SHALL become 1 on the first cycle after reset returns to 1.
REQ-027 Reset asserted mid-operation (RD, WR or RESP) SHALL abort the operation; a write not yet performed in WR SHALL NOT occur, and memory contents SHALL NOT be cleared by reset.

Structure
REQ-028 A shared package SHALL hold the wbh encodings (WBH_WORD, WBH_HALF, WBH_BYTE), the FSM state enumeration and the ADDR_W default.
REQ-029 The storage array SHALL be one sub-module, dmem_array: a single-port synchronous-read RAM with a full-word write enable.

Verification
REQ-030 Word write of 0xDEADBEEF to 0x0010, then a word read of 0x0010 -> resp_rdata=0xDEADBEEF, resp_err=0, resp_valid 2 cycles after each accept.
REQ-031 Byte write of 0xAA to 0x0011 over 0xDEADBEEF, then word read of 0x0010 -> 0xDEADAAEF; resp_valid 3 cycles after the write accept.
REQ-032 Halfword read of 0x0012 after REQ-031 -> resp_rdata=0x0000DEAD; halfword write to 0x0013 -> resp_err=1 one cycle after accept and memory unchanged.
REQ-033 Hold resp_ready=0 for 5 cycles in RESP -> resp_valid=1 and resp_rdata stable throughout, req_ready=0; after resp_ready=1 -> IDLE and req_ready=1 on the next cycle.
REQ-034 reset=0 asserted in WR of a byte write to 0x0020 (prior word 0x11223344) -> outputs zero, word read of 0x0020 after release -> 0x11223344.
